// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (1 start bit, LEN_DATA data bits LSB
// first, 1 stop bit, no parity). The serial line is synchronised through two
// flops and a single FSM samples it on s_tick strobes at mid-bit positions.
// LEN_DATA is expected to be at least 2 (the shift register slices bit 1 up).
module uart_rx #(
    parameter int LEN_DATA       = 8,
    parameter int NUM_TICKS      = 16,
    parameter int NUM_STOP_TICKS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic                s_tick,
    output logic                rx_done_tick,
    output logic [LEN_DATA-1:0] data_out,
    output logic                frame_error
);

    // The tick counter must hold the largest terminal count of any state.
    localparam int TMAX = (NUM_TICKS > NUM_STOP_TICKS) ? NUM_TICKS : NUM_STOP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (LEN_DATA > 1) ? $clog2(LEN_DATA) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(NUM_TICKS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(NUM_TICKS - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(NUM_STOP_TICKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(LEN_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;

    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [TW-1:0]          tick_d;
    logic [BW-1:0]          bit_q;
    logic [BW-1:0]          bit_d;
    logic [LEN_DATA-1:0]    shift_q;
    logic [LEN_DATA-1:0]    shift_d;
    logic [LEN_DATA-1:0]    data_q;
    logic                   done_q;
    logic                   ferr_q;

    // Two-flop synchroniser chain; both stages idle high so reset never
    // looks like a start bit.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous line.
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= rx;
                end
            end else begin : g_rest
                // Later stages resolve metastability of the previous stage.
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Next values of the datapath registers, used only when the FSM
    // decides to advance them.
    always_comb begin
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q + 1'b1;
        shift_d = {rx_sync, shift_q[LEN_DATA-1:1]};
    end

    // Receive FSM with registered pulse outputs; the pulses default low so
    // each one lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Falling edge is taken on any clock, not just on ticks.
                    if (!rx_sync) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_q == HALF_LAST) begin
                            // Mid start bit: still low means a real frame.
                            if (!rx_sync) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_q == BIT_LAST) begin
                            shift_q <= shift_d;
                            tick_q  <= '0;
                            bit_q   <= bit_d;
                            if (bit_q == DATA_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_q == STOP_LAST) begin
                            if (rx_sync) begin
                                data_q <= shift_q;
                                done_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign frame_error  = ferr_q;
    assign data_out     = data_q;

endmodule
